alu_seq: RTL and testbench

Parametrised, handshaked execution unit for the TSC datapath. It replaces the purely combinational ALU with a registered unit that keeps the full existing opcode and function set, generalised to `WIDTH` bits. It adds iterative unsigned multiply, iterative unsigned divide and variable shifts. It sits between the register-read stage and the memory/writeback stage, and the pipeline stalls on `in_ready`/`out_valid`.

---
 rtl/alu_seq_pkg.sv | 41 ++++
 rtl/alu_muldiv_iter.sv | 98 +++++++++
 rtl/alu_seq.sv | 153 +++++++++++++++
 tb/tb_alu_seq.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared constants for the TSC sequential ALU: opcodes, function codes and FSM states.
// FUNC_DIV is only decoded when ALU_DIV_EN is defined.
package alu_seq_pkg;

    localparam int WORD_SIZE = 16;

    localparam logic [3:0] OP_BNE = 4'd0;
    localparam logic [3:0] OP_BEQ = 4'd1;
    localparam logic [3:0] OP_BGZ = 4'd2;
    localparam logic [3:0] OP_BLZ = 4'd3;
    localparam logic [3:0] OP_ADI = 4'd4;
    localparam logic [3:0] OP_ORI = 4'd5;
    localparam logic [3:0] OP_LHI = 4'd6;
    localparam logic [3:0] OP_LWD = 4'd7;
    localparam logic [3:0] OP_SWD = 4'd8;
    localparam logic [3:0] OP_ALU = 4'd15;

    localparam logic [5:0] FUNC_ADD  = 6'd0;
    localparam logic [5:0] FUNC_SUB  = 6'd1;
    localparam logic [5:0] FUNC_AND  = 6'd2;
    localparam logic [5:0] FUNC_ORR  = 6'd3;
    localparam logic [5:0] FUNC_NOT  = 6'd4;
    localparam logic [5:0] FUNC_TCP  = 6'd5;
    localparam logic [5:0] FUNC_SHL  = 6'd6;
    localparam logic [5:0] FUNC_SHR  = 6'd7;
    localparam logic [5:0] FUNC_MUL  = 6'd8;
    localparam logic [5:0] FUNC_DIV  = 6'd9;
    localparam logic [5:0] FUNC_SLLV = 6'd10;
    localparam logic [5:0] FUNC_SRAV = 6'd11;

    typedef enum logic [1:0] {
        ALU_ST_IDLE = 2'd0,
        ALU_ST_CALC = 2'd1,
        ALU_ST_DONE = 2'd2
    } aluState_t;

    function automatic logic isBranchOp(input logic [3:0] op);
        return (op == OP_BNE) || (op == OP_BEQ) || (op == OP_BGZ) || (op == OP_BLZ);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiplier (shift-add) and restoring divider sharing one adder.
// The divide step is built only when ALU_DIV_EN is defined.
module alu_muldiv_iter
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = WORD_SIZE
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
`ifdef ALU_DIV_EN
    input  logic             i_isDiv,
`endif
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_lastStep,
    output logic [WIDTH-1:0] o_nextLo,
    output logic [WIDTH-1:0] o_nextHi
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_op;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] w_nextHi;
    logic [WIDTH-1:0] w_nextLo;

`ifdef ALU_DIV_EN
    logic             r_isDiv;
    logic [WIDTH:0]   w_addA;
    logic [WIDTH:0]   w_addB;
    logic [WIDTH+1:0] w_sum;

    // Divide reuses the adder as a subtractor; the top carry means "no borrow".
    assign w_addA = r_isDiv ? {r_hi, r_lo[WIDTH-1]} : {1'b0, r_hi};
    assign w_addB = r_isDiv ? ~{1'b0, r_op} : {1'b0, r_op};
    assign w_sum  = {1'b0, w_addA} + {1'b0, w_addB} + {{(WIDTH+1){1'b0}}, r_isDiv};
`else
    logic [WIDTH:0]   w_sum;

    assign w_sum = {1'b0, r_hi} + {1'b0, r_op};
`endif

    always_comb begin
        w_nextHi = r_hi;
        w_nextLo = r_lo;
`ifdef ALU_DIV_EN
        if (r_isDiv) begin
            if (w_sum[WIDTH+1]) begin
                w_nextHi = w_sum[WIDTH-1:0];
                w_nextLo = {r_lo[WIDTH-2:0], 1'b1};
            end else begin
                w_nextHi = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
                w_nextLo = {r_lo[WIDTH-2:0], 1'b0};
            end
        end else
`endif
        if (r_lo[0]) begin
            w_nextHi = w_sum[WIDTH:1];
            w_nextLo = {w_sum[0], r_lo[WIDTH-1:1]};
        end else begin
            w_nextHi = {1'b0, r_hi[WIDTH-1:1]};
            w_nextLo = {r_hi[0], r_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi    <= '0;
            r_lo    <= '0;
            r_op    <= '0;
            r_count <= '0;
`ifdef ALU_DIV_EN
            r_isDiv <= 1'b0;
`endif
        end else if (i_start) begin
            r_hi    <= '0;
            r_lo    <= i_a;
            r_op    <= i_b;
            r_count <= CNT_W'(WIDTH);
`ifdef ALU_DIV_EN
            r_isDiv <= i_isDiv;
`endif
        end else if (r_count != '0) begin
            r_hi    <= w_nextHi;
            r_lo    <= w_nextLo;
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_lastStep = (r_count == CNT_W'(1));
    assign o_nextLo   = w_nextLo;
    assign o_nextHi   = w_nextHi;

endmodule

// File: rtl/alu_seq.sv
// Handshaked execution unit: single-cycle ALU ops plus iterative MUL/DIV via alu_muldiv_iter.
// Define ALU_DIV_EN to build the divider; otherwise FUNC_DIV decodes as an undefined function.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = WORD_SIZE
)
(
    input  logic             clk,
    input  logic             Reset_N,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       Opcode,
    input  logic [5:0]       FuncCode,
    input  logic [WIDTH-1:0] read1,
    input  logic [WIDTH-1:0] ALUinput,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUresult,
    output logic [WIDTH-1:0] ALUresult_hi,
    output logic             Bcond
);

    localparam int SHAMT_W = $clog2(WIDTH);

    aluState_t          r_state;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_resultHi;
    logic               r_bcond;

    logic               w_accept;
    logic               w_start;
    logic [WIDTH-1:0]   w_res;
    logic [WIDTH-1:0]   w_resHi;
    logic               w_bcond;
    logic [SHAMT_W-1:0] w_shamt;
    logic               w_lastStep;
    logic [WIDTH-1:0]   w_stepLo;
    logic [WIDTH-1:0]   w_stepHi;
`ifdef ALU_DIV_EN
    logic               w_isDiv;
`endif

    assign in_ready  = (r_state == ALU_ST_IDLE) | ((r_state == ALU_ST_DONE) & out_ready);
    assign out_valid = (r_state == ALU_ST_DONE);
    assign w_accept  = in_valid & in_ready;
    assign w_shamt   = ALUinput[SHAMT_W-1:0];

    always_comb begin
        w_res   = '0;
        w_resHi = '0;
        w_bcond = 1'b0;
        w_start = 1'b0;
`ifdef ALU_DIV_EN
        w_isDiv = 1'b0;
`endif
        case (Opcode)
            OP_ALU: begin
                case (FuncCode)
                    FUNC_ADD:  w_res = read1 + ALUinput;
                    FUNC_SUB:  w_res = read1 - ALUinput;
                    FUNC_AND:  w_res = read1 & ALUinput;
                    FUNC_ORR:  w_res = read1 | ALUinput;
                    FUNC_NOT:  w_res = ~read1;
                    FUNC_TCP:  w_res = -read1;
                    FUNC_SHL:  w_res = {read1[WIDTH-2:0], 1'b0};
                    FUNC_SHR:  w_res = {read1[WIDTH-1], read1[WIDTH-1:1]};
                    FUNC_SLLV: w_res = read1 << w_shamt;
                    FUNC_SRAV: w_res = $unsigned($signed(read1) >>> w_shamt);
                    FUNC_MUL:  w_start = 1'b1;
`ifdef ALU_DIV_EN
                    // Divide by zero resolves immediately instead of iterating.
                    FUNC_DIV: begin
                        if (ALUinput == '0) begin
                            w_res   = '1;
                            w_resHi = read1;
                        end else begin
                            w_start = 1'b1;
                            w_isDiv = 1'b1;
                        end
                    end
`endif
                    default:   w_res = '1;
                endcase
            end
            OP_ADI, OP_LWD, OP_SWD: w_res = read1 + ALUinput;
            OP_ORI: w_res = read1 | {{(WIDTH/2){1'b0}}, ALUinput[WIDTH/2-1:0]};
            OP_LHI: w_res = {ALUinput[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_BNE: w_bcond = (read1 != ALUinput);
            OP_BEQ: w_bcond = (read1 == ALUinput);
            OP_BGZ: w_bcond = !read1[WIDTH-1] && (read1 != '0);
            OP_BLZ: w_bcond = read1[WIDTH-1];
            default: ;
        endcase
    end

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk        (clk),
        .rst_n      (Reset_N),
        .i_start    (w_accept & w_start),
`ifdef ALU_DIV_EN
        .i_isDiv    (w_isDiv),
`endif
        .i_a        (read1),
        .i_b        (ALUinput),
        .o_lastStep (w_lastStep),
        .o_nextLo   (w_stepLo),
        .o_nextHi   (w_stepHi)
    );

    // DONE accepts the next op on the same edge the consumer takes the result.
    always_ff @(posedge clk or negedge Reset_N) begin
        if (!Reset_N) begin
            r_state    <= ALU_ST_IDLE;
            r_result   <= '0;
            r_resultHi <= '0;
            r_bcond    <= 1'b0;
        end else begin
            case (r_state)
                ALU_ST_IDLE, ALU_ST_DONE: begin
                    if (w_accept) begin
                        if (w_start) begin
                            r_state    <= ALU_ST_CALC;
                            r_result   <= '0;
                            r_resultHi <= '0;
                            r_bcond    <= 1'b0;
                        end else begin
                            r_state    <= ALU_ST_DONE;
                            r_result   <= w_res;
                            r_resultHi <= w_resHi;
                            r_bcond    <= w_bcond;
                        end
                    end else if ((r_state == ALU_ST_DONE) && out_ready) begin
                        r_state <= ALU_ST_IDLE;
                    end
                end
                ALU_ST_CALC: begin
                    if (w_lastStep) begin
                        r_state    <= ALU_ST_DONE;
                        r_result   <= w_stepLo;
                        r_resultHi <= w_stepHi;
                    end
                end
                default: r_state <= ALU_ST_IDLE;
            endcase
        end
    end

    assign ALUresult    = r_result;
    assign ALUresult_hi = r_resultHi;
    assign Bcond        = r_bcond;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: stimulus pushes expected results, a negedge monitor checks them.
// DIV expectations follow ALU_DIV_EN.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             Reset_N;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       Opcode;
    logic [5:0]       FuncCode;
    logic [WIDTH-1:0] read1;
    logic [WIDTH-1:0] ALUinput;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALUresult;
    logic [WIDTH-1:0] ALUresult_hi;
    logic             Bcond;

    typedef struct {
        string      name;
        logic [15:0] res;
        logic [15:0] hi;
        logic        bc;
        int          lat;
        int          acc;
    } expItem_t;

    expItem_t sb[$];
    int  cycle      = 0;
    int  checkCount = 0;
    int  passCount  = 0;
    bit  seen       = 1'b0;
    int  firstCyc   = 0;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .Reset_N      (Reset_N),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .Opcode       (Opcode),
        .FuncCode     (FuncCode),
        .read1        (read1),
        .ALUinput     (ALUinput),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .ALUresult    (ALUresult),
        .ALUresult_hi (ALUresult_hi),
        .Bcond        (Bcond)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input string name, input logic [3:0] op, input logic [5:0] fn,
                                 input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] eRes, input logic [15:0] eHi,
                                 input logic eBc, input int eLat, output int attempts);
        expItem_t item;
        int accCyc;
        bit ok;
        ok       = 1'b0;
        accCyc   = 0;
        attempts = 0;
        Opcode   = op;
        FuncCode = fn;
        read1    = a;
        ALUinput = b;
        in_valid = 1'b1;
        while (!ok && attempts < 200) begin
            @(negedge clk);
            ok     = in_ready;
            accCyc = cycle;
            attempts++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            checkOutput({name, "_accept_timeout"}, 32'(attempts), 32'(0));
        end else begin
            item.name = name;
            item.res  = eRes;
            item.hi   = eHi;
            item.bc   = eBc;
            item.lat  = eLat;
            item.acc  = accCyc;
            sb.push_back(item);
        end
    endtask

    task automatic checkBusy(input int n);
        repeat (n) begin
            @(negedge clk);
            checkOutput("busy_in_ready", 32'(in_ready), 32'(0));
        end
    endtask

    task automatic waitDrain();
        int waited;
        waited = 0;
        while (sb.size() != 0 && waited < 100) begin
            tick();
            waited++;
        end
        if (sb.size() != 0) checkOutput("drain_timeout", 32'(sb.size()), 32'(0));
    endtask

    // Results are compared only at the handshake; while back-pressured the head is checked for stability.
    always @(negedge clk) begin
        expItem_t e;
        if (Reset_N && out_valid) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_out_valid", 32'(out_valid), 32'(0));
            end else begin
                if (!seen) begin
                    seen     = 1'b1;
                    firstCyc = cycle;
                end
                if (!out_ready) begin
                    checkOutput({sb[0].name, "_hold"}, 32'(ALUresult), 32'(sb[0].res));
                end else begin
                    e = sb.pop_front();
                    seen = 1'b0;
                    checkOutput({e.name, "_res"}, 32'(ALUresult), 32'(e.res));
                    checkOutput({e.name, "_hi"}, 32'(ALUresult_hi), 32'(e.hi));
                    checkOutput({e.name, "_bcond"}, 32'(Bcond), 32'(e.bc));
                    checkOutput({e.name, "_latency"}, 32'(firstCyc - e.acc), 32'(e.lat));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int att;
        Reset_N   = 1'b0;
        in_valid  = 1'b0;
        Opcode    = '0;
        FuncCode  = '0;
        read1     = '0;
        ALUinput  = '0;
        out_ready = 1'b1;
        #3;
        checkOutput("rst_out_valid", 32'(out_valid), 32'(0));
        checkOutput("rst_result", 32'(ALUresult), 32'(0));
        checkOutput("rst_result_hi", 32'(ALUresult_hi), 32'(0));
        checkOutput("rst_bcond", 32'(Bcond), 32'(0));
        @(negedge clk);
        Reset_N = 1'b1;
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'(1));
        tick();

        // Reset during CALC of a multiply aborts it: no result may appear afterwards.
        applyStimulus("mul_abort", OP_ALU, FUNC_MUL, 16'h0003, 16'h0005, 16'h000F, 16'h0000, 1'b0, 17, att);
        repeat (4) tick();
        Reset_N = 1'b0;
        sb.delete();
        seen = 1'b0;
        #1;
        checkOutput("abort_out_valid", 32'(out_valid), 32'(0));
        checkOutput("abort_result", 32'(ALUresult), 32'(0));
        checkOutput("abort_result_hi", 32'(ALUresult_hi), 32'(0));
        @(negedge clk);
        Reset_N = 1'b1;
        #1;
        checkOutput("abort_in_ready", 32'(in_ready), 32'(1));
        repeat (20) tick();

        applyStimulus("add_ovf", OP_ALU, FUNC_ADD, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1, att);
        applyStimulus("blz_b2b", OP_BLZ, 6'd0, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1, att);
        checkOutput("blz_b2b_attempts", 32'(att), 32'(1));
        waitDrain();

        applyStimulus("mul_ffff", OP_ALU, FUNC_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 17, att);
        checkBusy(16);
        waitDrain();
        applyStimulus("mul_small", OP_ALU, FUNC_MUL, 16'h0003, 16'h0005, 16'h000F, 16'h0000, 1'b0, 17, att);
        applyStimulus("mul_shift", OP_ALU, FUNC_MUL, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 1'b0, 17, att);

`ifdef ALU_DIV_EN
        applyStimulus("div_100_7", OP_ALU, FUNC_DIV, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17, att);
        applyStimulus("div_by0", OP_ALU, FUNC_DIV, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b0, 1, att);
        applyStimulus("div_by1", OP_ALU, FUNC_DIV, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 17, att);
        applyStimulus("div_8000_3", OP_ALU, FUNC_DIV, 16'h8000, 16'h0003, 16'h2AAA, 16'h0002, 1'b0, 17, att);
`else
        applyStimulus("div_100_7", OP_ALU, FUNC_DIV, 16'd100, 16'd7, 16'hFFFF, 16'h0000, 1'b0, 1, att);
        applyStimulus("div_by0", OP_ALU, FUNC_DIV, 16'h1234, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 1, att);
`endif

        applyStimulus("srav", OP_ALU, FUNC_SRAV, 16'h8000, 16'd15, 16'hFFFF, 16'h0000, 1'b0, 1, att);
        applyStimulus("sllv_mask", OP_ALU, FUNC_SLLV, 16'h0001, 16'd17, 16'h0002, 16'h0000, 1'b0, 1, att);
        applyStimulus("lhi", OP_LHI, 6'd0, 16'h5555, 16'h00AB, 16'hAB00, 16'h0000, 1'b0, 1, att);
        applyStimulus("ori", OP_ORI, 6'd0, 16'h1200, 16'hFF34, 16'h1234, 16'h0000, 1'b0, 1, att);
        applyStimulus("sub", OP_ALU, FUNC_SUB, 16'h0010, 16'h0003, 16'h000D, 16'h0000, 1'b0, 1, att);
        applyStimulus("and", OP_ALU, FUNC_AND, 16'hF0F0, 16'h3C3C, 16'h3030, 16'h0000, 1'b0, 1, att);
        applyStimulus("orr", OP_ALU, FUNC_ORR, 16'hF000, 16'h000F, 16'hF00F, 16'h0000, 1'b0, 1, att);
        applyStimulus("not", OP_ALU, FUNC_NOT, 16'h00FF, 16'h1234, 16'hFF00, 16'h0000, 1'b0, 1, att);
        applyStimulus("tcp", OP_ALU, FUNC_TCP, 16'h0001, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 1, att);
        applyStimulus("shl", OP_ALU, FUNC_SHL, 16'h8001, 16'h0000, 16'h0002, 16'h0000, 1'b0, 1, att);
        applyStimulus("shr", OP_ALU, FUNC_SHR, 16'h8002, 16'h0000, 16'hC001, 16'h0000, 1'b0, 1, att);
        applyStimulus("undef_func", OP_ALU, 6'd20, 16'h1111, 16'h2222, 16'hFFFF, 16'h0000, 1'b0, 1, att);
        applyStimulus("other_op", 4'd9, 6'd0, 16'h1111, 16'h2222, 16'h0000, 16'h0000, 1'b0, 1, att);
        applyStimulus("adi", OP_ADI, 6'd0, 16'h0010, 16'hFFFF, 16'h000F, 16'h0000, 1'b0, 1, att);
        applyStimulus("bne", OP_BNE, 6'd0, 16'h0005, 16'h0006, 16'h0000, 16'h0000, 1'b1, 1, att);
        applyStimulus("beq", OP_BEQ, 6'd0, 16'h0005, 16'h0006, 16'h0000, 16'h0000, 1'b0, 1, att);
        applyStimulus("bgz_zero", OP_BGZ, 6'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1, att);
        applyStimulus("bgz_pos", OP_BGZ, 6'd0, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1, att);
        waitDrain();

        // Backpressure: result must hold, then a new op is taken on the edge out_ready rises.
        out_ready = 1'b0;
        applyStimulus("bp_sub", OP_ALU, FUNC_SUB, 16'd5, 16'd7, 16'hFFFE, 16'h0000, 1'b0, 1, att);
        checkBusy(10);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        applyStimulus("bp_next", OP_ALU, FUNC_ADD, 16'h0001, 16'h0002, 16'h0003, 16'h0000, 1'b0, 1, att);
        checkOutput("bp_same_edge_accept", 32'(att), 32'(1));
        waitDrain();

        // Reset while a result is pending in DONE drops it.
        out_ready = 1'b0;
        applyStimulus("done_abort", OP_ALU, FUNC_ADD, 16'h1000, 16'h0111, 16'h1111, 16'h0000, 1'b0, 1, att);
        repeat (2) tick();
        Reset_N = 1'b0;
        sb.delete();
        seen = 1'b0;
        #1;
        checkOutput("done_abort_out_valid", 32'(out_valid), 32'(0));
        checkOutput("done_abort_result", 32'(ALUresult), 32'(0));
        @(negedge clk);
        Reset_N   = 1'b1;
        out_ready = 1'b1;
        #1;
        checkOutput("done_abort_in_ready", 32'(in_ready), 32'(1));
        repeat (5) tick();

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
